// File: rtl/sd_tx_fifo_filler_pkg.sv
// Shared constants and types for the SD TX FIFO filler.
// FIFO sizing mirrors the shared SD defines so level compares match the FIFO.
package sd_tx_fifo_filler_pkg;

  localparam int SD_FIFO_ADR_SIZE = 5;
  localparam int SD_FIFO_DEPTH    = 16;
  localparam int SD_LVL_W         = SD_FIFO_ADR_SIZE + 1;
  localparam int SD_LEN_W         = 16;

  localparam logic [3:0]  WB_SEL_ALL  = 4'hF;
  localparam logic [31:0] WB_WORD_INC = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_REQ        = 2'd1,
    ST_PUSH       = 2'd2,
    ST_WAIT_SPACE = 2'd3
  } filler_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] byte_adr);
    return byte_adr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/sd_tx_fifo_filler.sv
// Wishbone read engine that streams memory words into the SD TX FIFO,
// one outstanding single-word read at a time, paced by the FIFO fill level.
//
// state         | meaning
// --------------+---------------------------------------------------------
// ST_IDLE       | no transfer; also finishes a zero-length transfer
// ST_REQ        | cyc/stb asserted, waiting for ack or err
// ST_PUSH       | write latched word to FIFO, advance address and count
// ST_WAIT_SPACE | FIFO full, hold off the next read
module sd_tx_fifo_filler
  import sd_tx_fifo_filler_pkg::*;
#(
  parameter int FIFO_DEPTH = SD_FIFO_DEPTH,
  parameter int LVL_W      = SD_LVL_W,
  parameter int LEN_W      = SD_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [31:0]      adr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic [31:0]      m_wb_adr_o,
  output logic             m_wb_cyc_o,
  output logic             m_wb_stb_o,
  output logic             m_wb_we_o,
  output logic [3:0]       m_wb_sel_o,
  input  logic [31:0]      m_wb_dat_i,
  input  logic             m_wb_ack_i,
  input  logic             m_wb_err_i,
  output logic [31:0]      fifo_d_o,
  output logic             fifo_wr_o,
  input  logic [LVL_W-1:0] fifo_level_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [LEN_W-1:0] words_left_o
);

  localparam logic [LVL_W-1:0] LVL_FULL    = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_PUSH_OK = LVL_W'(FIFO_DEPTH - 2);
  localparam logic [LEN_W-1:0] LEN_ONE     = LEN_W'(1);

  filler_state_e    state_q, state_d;
  logic [31:0]      adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic [LEN_W-1:0] left_q, left_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             abort_q, abort_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      left_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      left_q  <= left_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    left_d  = left_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    abort_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // busy in IDLE only happens for an accepted zero-length start
        if (busy_q) begin
          busy_d = 1'b0;
          done_d = !abort_i;
        end else if (start_i && !abort_i) begin
          err_d  = 1'b0;
          adr_d  = word_align(adr_i);
          left_d = len_i;
          busy_d = 1'b1;
          if (len_i != '0) begin
            state_d = (fifo_level_i < LVL_FULL) ? ST_REQ : ST_WAIT_SPACE;
          end
        end
      end

      ST_REQ: begin
        // an abort is remembered but the bus cycle always runs to completion
        abort_d = abort_q | abort_i;
        if (m_wb_err_i) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          abort_d = 1'b0;
          state_d = ST_IDLE;
        end else if (m_wb_ack_i) begin
          abort_d = 1'b0;
          if (abort_q || abort_i) begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            dat_d   = m_wb_dat_i;
            state_d = ST_PUSH;
          end
        end
      end

      ST_PUSH: begin
        left_d = left_q - LEN_ONE;
        adr_d  = adr_q + WB_WORD_INC;
        if (abort_i) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (left_q == LEN_ONE) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (fifo_level_i <= LVL_PUSH_OK) begin
          // level excludes this cycle's write, so leave a slot for it
          state_d = ST_REQ;
        end else begin
          state_d = ST_WAIT_SPACE;
        end
      end

      ST_WAIT_SPACE: begin
        if (abort_i) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (fifo_level_i < LVL_FULL) begin
          state_d = ST_REQ;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign m_wb_adr_o   = adr_q;
  assign m_wb_cyc_o   = (state_q == ST_REQ);
  assign m_wb_stb_o   = (state_q == ST_REQ);
  assign m_wb_we_o    = 1'b0;
  assign m_wb_sel_o   = WB_SEL_ALL;
  assign fifo_d_o     = dat_q;
  assign fifo_wr_o    = (state_q == ST_PUSH);
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign words_left_o = left_q;

endmodule

// File: tb/tb_sd_tx_fifo_filler.sv
// Bench for sd_tx_fifo_filler: Wishbone slave model, FIFO occupancy model,
// and address/data scoreboards filled when each transfer is started.
module tb_sd_tx_fifo_filler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [31:0] adr_i = '0;
  logic [15:0] len_i = '0;
  logic [31:0] m_wb_adr_o;
  logic        m_wb_cyc_o, m_wb_stb_o, m_wb_we_o;
  logic [3:0]  m_wb_sel_o;
  logic [31:0] m_wb_dat_i = '0;
  logic        m_wb_ack_i = 1'b0;
  logic        m_wb_err_i = 1'b0;
  logic [31:0] fifo_d_o;
  logic        fifo_wr_o;
  logic [5:0]  occ = '0;
  logic        busy_o, done_o, err_o;
  logic [15:0] words_left_o;

  int checks = 0;
  int errors = 0;

  int          ack_wait = 0;
  logic [31:0] err_adr = 32'h1;
  int          wcnt = 0;
  logic        occ_load = 1'b0;
  logic        drain = 1'b0;
  logic [5:0]  occ_val = '0;

  logic [31:0] exp_adr[$];
  logic [31:0] exp_dat[$];
  int          wr_times[$];
  int wr_total = 0, done_total = 0, cyc_total = 0, stb_full = 0;
  int cyc_n = 0, last_ack_cyc = 0, last_done_cyc = 0;

  always #5 clk = ~clk;

  sd_tx_fifo_filler #(.FIFO_DEPTH(16), .LVL_W(6), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .adr_i(adr_i), .len_i(len_i),
    .m_wb_adr_o(m_wb_adr_o), .m_wb_cyc_o(m_wb_cyc_o), .m_wb_stb_o(m_wb_stb_o),
    .m_wb_we_o(m_wb_we_o), .m_wb_sel_o(m_wb_sel_o), .m_wb_dat_i(m_wb_dat_i),
    .m_wb_ack_i(m_wb_ack_i), .m_wb_err_i(m_wb_err_i),
    .fifo_d_o(fifo_d_o), .fifo_wr_o(fifo_wr_o), .fifo_level_i(occ),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .words_left_o(words_left_o)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A11;
  endfunction

  // Wishbone slave: registered ack after ack_wait extra cycles, err at err_adr
  always @(posedge clk) begin
    m_wb_ack_i <= 1'b0;
    m_wb_err_i <= 1'b0;
    if (m_wb_cyc_o && m_wb_stb_o && !m_wb_ack_i && !m_wb_err_i) begin
      if (wcnt >= ack_wait) begin
        wcnt <= 0;
        if (m_wb_adr_o == err_adr) m_wb_err_i <= 1'b1;
        else begin
          m_wb_ack_i <= 1'b1;
          m_wb_dat_i <= mem_word(m_wb_adr_o);
        end
      end else wcnt <= wcnt + 1;
    end else if (!m_wb_cyc_o) wcnt <= 0;
  end

  // TX FIFO occupancy: grows on accepted writes, shrinks while drain is high
  always @(posedge clk) begin
    if (occ_load) occ <= occ_val;
    else occ <= occ + ((fifo_wr_o && occ < 6'd16) ? 6'd1 : 6'd0)
                    - ((drain && occ > 6'd0) ? 6'd1 : 6'd0);
  end

  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (m_wb_cyc_o && (m_wb_ack_i || m_wb_err_i)) begin
        last_ack_cyc = cyc_n;
        checks++;
        if (exp_adr.size() == 0) begin
          errors++; $display("FAIL rd_adr unexpected read got %h", m_wb_adr_o);
        end else begin
          e = exp_adr.pop_front();
          if (m_wb_adr_o !== e) begin
            errors++; $display("FAIL rd_adr got %h expected %h", m_wb_adr_o, e);
          end
        end
      end
      if (fifo_wr_o) begin
        wr_total++;
        wr_times.push_back(cyc_n);
        checks++;
        if (occ >= 6'd16) begin
          errors++; $display("FAIL wr_full write with level %0d expected below 16", occ);
        end
        checks++;
        if (exp_dat.size() == 0) begin
          errors++; $display("FAIL wr_dat unexpected write got %h", fifo_d_o);
        end else begin
          e = exp_dat.pop_front();
          if (fifo_d_o !== e) begin
            errors++; $display("FAIL wr_dat got %h expected %h", fifo_d_o, e);
          end
        end
      end
      if (done_o) begin done_total++; last_done_cyc = cyc_n; end
      if (m_wb_cyc_o) cyc_total++;
      if (m_wb_stb_o && occ == 6'd16) stb_full++;
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input int nrd, input int nwr);
    logic [31:0] x;
    for (int i = 0; i < nrd; i++) begin
      x = (a & 32'hFFFF_FFFC) + 32'(4 * i);
      exp_adr.push_back(x);
      if (i < nwr) exp_dat.push_back(mem_word(x));
    end
  endtask

  task automatic do_start(input logic [31:0] a, input logic [15:0] n);
    @(negedge clk);
    adr_i = a; len_i = n; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic set_level(input logic [5:0] v);
    @(negedge clk); occ_load = 1'b1; occ_val = v;
    @(negedge clk); occ_load = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy_o && n < budget) begin @(negedge clk); n++; end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL %s_timeout busy %b expected 0", tag, busy_o);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, fifo_wr_o, busy_o, done_o, err_o} !== 7'b0) begin
      errors++; $display("FAIL reset_ctl got %b expected 0000000",
        {m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, fifo_wr_o, busy_o, done_o, err_o});
    end
    checks++;
    if (m_wb_adr_o !== 32'h0 || words_left_o !== 16'h0 || fifo_d_o !== 32'h0) begin
      errors++; $display("FAIL reset_data adr %h left %h dat %h expected zeros",
        m_wb_adr_o, words_left_o, fifo_d_o);
    end
    checks++;
    if (m_wb_sel_o !== 4'hF) begin errors++; $display("FAIL sel got %h expected f", m_wb_sel_o); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int dn0;
    ack_wait = 0; set_level(6'd0);
    push_exp(32'h1000, 4, 4);
    dn0 = done_total;
    wr_times.delete();
    do_start(32'h1000, 16'd4);
    checks++;
    if (words_left_o !== 16'd4 || busy_o !== 1'b1) begin
      errors++; $display("FAIL basic_start left %0d busy %b expected 4 1", words_left_o, busy_o);
    end
    wait_idle(100, "basic");
    checks++;
    if (wr_times.size() != 4) begin
      errors++; $display("FAIL basic_writes got %0d expected 4", wr_times.size());
    end else begin
      checks++;
      if (wr_times[1] - wr_times[0] != 3 || wr_times[2] - wr_times[1] != 3 || wr_times[3] - wr_times[2] != 3) begin
        errors++; $display("FAIL basic_gap got %0d %0d %0d expected 3 3 3",
          wr_times[1] - wr_times[0], wr_times[2] - wr_times[1], wr_times[3] - wr_times[2]);
      end
      checks++;
      if (last_done_cyc - wr_times[3] != 1) begin
        errors++; $display("FAIL basic_done_lat got %0d expected 1", last_done_cyc - wr_times[3]);
      end
      checks++;
      if (wr_times[3] - last_ack_cyc != 1) begin
        errors++; $display("FAIL ack_to_wr got %0d expected 1", wr_times[3] - last_ack_cyc);
      end
    end
    checks++;
    if (done_total - dn0 != 1 || words_left_o !== 16'd0) begin
      errors++; $display("FAIL basic_end done %0d left %0d expected 1 0", done_total - dn0, words_left_o);
    end
  endtask

  task automatic test_zero_len();
    int cy0;
    cy0 = cyc_total;
    do_start(32'h7000, 16'd0);
    checks++;
    if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      errors++; $display("FAIL zero_c1 busy %b done %b expected 1 0", busy_o, done_o);
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b1) begin
      errors++; $display("FAIL zero_c2 busy %b done %b expected 0 1", busy_o, done_o);
    end
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0 || cyc_total != cy0) begin
      errors++; $display("FAIL zero_c3 done %b cyc %0d expected 0 0", done_o, cyc_total - cy0);
    end
  endtask

  task automatic test_wrap();
    int wr0;
    set_level(6'd0);
    wr0 = wr_total;
    push_exp(32'hFFFF_FFFE, 2, 2);
    do_start(32'hFFFF_FFFE, 16'd2);
    wait_idle(100, "wrap");
    checks++;
    if (wr_total - wr0 != 2 || m_wb_adr_o !== 32'h4) begin
      errors++; $display("FAIL wrap writes %0d adr %h expected 2 00000004", wr_total - wr0, m_wb_adr_o);
    end
  endtask

  task automatic test_wait_space();
    int wr0, dn0, cy0, sf0, n;
    set_level(6'd15);
    wr0 = wr_total; dn0 = done_total; sf0 = stb_full;
    push_exp(32'h6000, 8, 8);
    do_start(32'h6000, 16'd8);
    n = 0;
    while (wr_total == wr0 && n < 50) begin @(negedge clk); n++; end
    cy0 = cyc_total;
    repeat (10) @(negedge clk);
    checks++;
    if (cyc_total != cy0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL ws_hold cyc %0d busy %b expected 0 1", cyc_total - cy0, busy_o);
    end
    drain = 1'b1;
    @(negedge clk);
    drain = 1'b0;
    checks++;
    if (m_wb_stb_o !== 1'b0) begin errors++; $display("FAIL ws_early stb %b expected 0", m_wb_stb_o); end
    @(negedge clk);
    checks++;
    if (m_wb_stb_o !== 1'b1) begin errors++; $display("FAIL ws_resume stb %b expected 1", m_wb_stb_o); end
    drain = 1'b1;
    wait_idle(300, "ws");
    drain = 1'b0;
    checks++;
    if (wr_total - wr0 != 8 || done_total - dn0 != 1 || stb_full != sf0) begin
      errors++; $display("FAIL ws_end writes %0d done %0d stb_full %0d expected 8 1 0",
        wr_total - wr0, done_total - dn0, stb_full - sf0);
    end
  endtask

  task automatic test_bus_error();
    int wr0, dn0;
    set_level(6'd0);
    wr0 = wr_total; dn0 = done_total;
    err_adr = 32'h2008;
    push_exp(32'h2000, 3, 2);
    do_start(32'h2000, 16'd10);
    wait_idle(100, "err");
    checks++;
    if (err_o !== 1'b1 || wr_total - wr0 != 2 || done_total != dn0) begin
      errors++; $display("FAIL err_end err %b writes %0d done %0d expected 1 2 0",
        err_o, wr_total - wr0, done_total - dn0);
    end
    err_adr = 32'h1;
    push_exp(32'h2100, 1, 1);
    do_start(32'h2100, 16'd1);
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL err_clear got %b expected 0", err_o); end
    wait_idle(100, "err2");
    checks++;
    if (done_total - dn0 != 1) begin
      errors++; $display("FAIL err2_done got %0d expected 1", done_total - dn0);
    end
  endtask

  task automatic test_abort_req();
    int wr0, dn0, n;
    bit dropped;
    set_level(6'd0);
    ack_wait = 5;
    wr0 = wr_total; dn0 = done_total;
    push_exp(32'h3000, 1, 0);
    do_start(32'h3000, 16'd3);
    n = 0;
    while (!m_wb_cyc_o && n < 20) begin @(negedge clk); n++; end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    n = 0; dropped = 1'b0;
    while (!m_wb_ack_i && n < 20) begin
      if (!m_wb_cyc_o) dropped = 1'b1;
      @(negedge clk); n++;
    end
    checks++;
    if (dropped || m_wb_ack_i !== 1'b1 || busy_o !== 1'b1) begin
      errors++; $display("FAIL abort_hold dropped %b ack %b busy %b expected 0 1 1", dropped, m_wb_ack_i, busy_o);
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || m_wb_cyc_o !== 1'b0) begin
      errors++; $display("FAIL abort_fall busy %b cyc %b expected 0 0", busy_o, m_wb_cyc_o);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_total != wr0 || done_total != dn0 || err_o !== 1'b0) begin
      errors++; $display("FAIL abort_end writes %0d done %0d err %b expected 0 0 0",
        wr_total - wr0, done_total - dn0, err_o);
    end
    ack_wait = 0;
  endtask

  task automatic test_reset_mid();
    int wr0, n;
    set_level(6'd0);
    ack_wait = 8;
    do_start(32'h4000, 16'd4);
    n = 0;
    while (!m_wb_cyc_o && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_wb_cyc_o, m_wb_stb_o, fifo_wr_o, busy_o, done_o, err_o} !== 6'b0) begin
      errors++; $display("FAIL rmid_ctl got %b expected 000000",
        {m_wb_cyc_o, m_wb_stb_o, fifo_wr_o, busy_o, done_o, err_o});
    end
    checks++;
    if (m_wb_adr_o !== 32'h0 || words_left_o !== 16'h0 || fifo_d_o !== 32'h0) begin
      errors++; $display("FAIL rmid_data adr %h left %h dat %h expected zeros",
        m_wb_adr_o, words_left_o, fifo_d_o);
    end
    rst = 1'b1;
    ack_wait = 0;
    wr0 = wr_total;
    push_exp(32'h5000, 2, 2);
    do_start(32'h5000, 16'd2);
    wait_idle(100, "rmid");
    checks++;
    if (wr_total - wr0 != 2 || words_left_o !== 16'd0) begin
      errors++; $display("FAIL rmid_after writes %0d left %0d expected 2 0", wr_total - wr0, words_left_o);
    end
  endtask

  task automatic test_scoreboard_empty();
    checks++;
    if (exp_adr.size() != 0 || exp_dat.size() != 0) begin
      errors++; $display("FAIL sb_left adr %0d dat %0d expected 0 0", exp_adr.size(), exp_dat.size());
    end
  endtask

  initial begin
    fork
      monitor();
      begin
        #1_000_000;
        $display("FAIL watchdog expired expected completion");
        $fatal(1, "watchdog");
      end
    join_none
    test_reset();
    test_basic();
    test_scoreboard_empty();
    test_zero_len();
    test_wrap();
    test_wait_space();
    test_scoreboard_empty();
    test_bus_error();
    test_abort_req();
    test_scoreboard_empty();
    test_reset_mid();
    test_scoreboard_empty();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_tx_fifo_filler.md
Name: sd_tx_fifo_filler

Overview:
- Wishbone-master fetch engine that keeps the SD TX FIFO supplied with data words from system memory during a block write.
- Software, via the SD register block, supplies a start byte address and a word count, then pulses start.
- The filler issues single-word Wishbone reads, pushes each returned word into the TX FIFO, and paces itself on the FIFO fill level.
- Sits between the system bus master port and the TX FIFO write side; the SD data serializer drains the FIFO independently.

Parameters:
- FIFO_DEPTH, 16, TX FIFO capacity in words; must match the FIFO depth constant in the shared defines.
- LVL_W, 6, width of the fill-level input (FIFO_ADR_SIZE+1).
- LEN_W, 16, width of the word-count input.

Ports:
- clk  in  1  single system clock.
- rst  in  1  reset, synchronous, active-low.
- start_i  in  1  one-cycle pulse that starts a transfer; ignored while busy_o=1.
- abort_i  in  1  level input that requests termination of the current transfer.
- adr_i  in  32  start byte address; bits [1:0] are ignored.
- len_i  in  LEN_W  number of 32-bit words to fetch.
- m_wb_adr_o  out  32  bus address.
- m_wb_cyc_o  out  1  bus cycle.
- m_wb_stb_o  out  1  bus strobe.
- m_wb_we_o  out  1  constant 0.
- m_wb_sel_o  out  4  constant 4'hF.
- m_wb_dat_i  in  32  read data.
- m_wb_ack_i  in  1  bus acknowledge.
- m_wb_err_i  in  1  bus error.
- fifo_d_o  out  32  write data to the TX FIFO.
- fifo_wr_o  out  1  TX FIFO write strobe.
- fifo_level_i  in  LVL_W  TX FIFO occupancy (the FIFO's mem_empt output).
- busy_o  out  1  high while a transfer is active.
- done_o  out  1  one-cycle pulse on successful completion.
- err_o  out  1  sticky bus-error flag; cleared by the next accepted start.
- words_left_o  out  LEN_W  remaining word count.

Behaviour:
- Reset: when rst=0 at a clk edge, every output goes to 0 (including m_wb_adr_o and words_left_o) and the state goes to IDLE.
- State machine: IDLE, REQ, PUSH, WAIT_SPACE.
- IDLE:
  - start_i accepted: err_o<=0, address<={adr_i[31:2],2'b00}, words_left_o<=len_i, busy_o<=1.
  - If len_i==0: done_o pulses next cycle, busy_o returns to 0, and no bus cycle is issued.
  - Otherwise go to REQ if fifo_level_i<FIFO_DEPTH, else go to WAIT_SPACE.
- REQ:
  - cyc/stb held high with a stable address until ack or err.
  - On ack: latch m_wb_dat_i into fifo_d_o, drop cyc/stb in the next cycle, go to PUSH.
  - On err: drop cyc/stb, err_o<=1, busy_o<=0, go to IDLE; no done_o, no FIFO write.
  - If both ack and err are high, err wins.
- PUSH:
  - fifo_wr_o=1 for exactly this one cycle; words_left_o decrements by 1; address increments by 4, wrapping modulo 2^32.
  - If the new count is 0: done_o pulses, busy_o<=0, go to IDLE.
  - Else if fifo_level_i<=FIFO_DEPTH-2: go to REQ. fifo_level_i does not yet include this write, so this test leaves room for it.
  - Else go to WAIT_SPACE.
- WAIT_SPACE: go to REQ when fifo_level_i<FIFO_DEPTH.
- Write rule: the filler never asserts fifo_wr_o while the FIFO is full. A full FIFO silently drops writes, so the bench must flag any such write as an error.
- Latency:
  - ack to fifo_wr_o: 1 cycle.
  - fifo_wr_o to the next stb: 1 cycle if there is space.
  - Steady state with zero-wait ack: 1 word per 3 cycles.
- Abort:
  - In IDLE, PUSH or WAIT_SPACE: go to IDLE at the next edge with busy_o=0 and no done_o. If the state was PUSH, that cycle's write still completes.
  - In REQ: keep cyc/stb until ack/err, discard the data, then go to IDLE. Wishbone cycles are never truncated.
- Restart: a start_i coinciding with abort_i, or arriving while busy, is ignored.
- At most one outstanding bus transaction at any time.

Decomposition:
- FIFO_DEPTH, FIFO address size and LEN_W come from the shared sd_defines.v constants.
- State encodings are local parameters in this module.
- No sub-module; a single FSM plus address and count registers.

Test Plan:
- Start at adr 0x1000 with len 4, zero-wait ack, level 0 -> reads at 0x1000, 0x1004, 0x1008, 0x100C; 4 fifo_wr_o pulses with matching data; done_o 1 cycle after the last write; words_left_o=0.
- Level held at 15 (depth 16) during a len-8 transfer -> after the first push (level then 16), the FSM enters WAIT_SPACE with no stb; stb resumes 1 cycle after level drops to 15; zero writes while level==16.
- err asserted on the 3rd read of a len-10 transfer -> err_o=1, busy_o=0, exactly 2 writes, no done_o; the next start clears err_o.
- abort_i during REQ with ack delayed 5 cycles -> cyc held until ack, no write, busy_o falls the cycle after ack, no done_o.
- Start with len 0 -> no cyc, done_o pulse, busy_o low afterwards. Start with adr 0xFFFFFFFE and len 2 -> reads at 0xFFFFFFFC then 0x00000000.
- rst=0 asserted mid-REQ -> all outputs 0 at the next edge; cyc drops; after release, a new start runs normally.
